// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the fetch FSM encoding, the queue entry layout and the fetch-address check.
package imem_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // A pc is fetchable when word aligned and inside the 2^addr_width-word memory.
    function automatic logic pc_fetchable(input logic [31:0] pc, input int unsigned addr_width);
        return (pc[1:0] == 2'b00) && ((pc >> (addr_width + 2)) == 32'd0);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_skid_q.sv
// Two-entry FIFO of {pc, inst} sitting between instruction memory and decode.
// Synchronous flush empties it; the head is a plain register read so outputs stay registered.
module imem_fetch_ctrl_skid_q
    import imem_fetch_ctrl_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i & ~flush_i & (count_q != 2'd0);
    assign do_push = push_i & ~flush_i & ((count_q != 2'd2) | do_pop);

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_i) begin
            // NOTE: both entries are reset because the head must read as a NOP/pc 0 out of reset.
            entry_q[0] <= '{pc: 32'h0, inst: INST_NOP};
            entry_q[1] <= '{pc: 32'h0, inst: INST_NOP};
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                entry_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count_o = count_q;
    assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the pc, drives the memory word address, checks it,
// queues fetched words and presents them to decode with a valid/ready handshake.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic [1:0]   q_count;
    fetch_entry_t q_head;
    fetch_entry_t push_entry;
    logic         out_fire;
    logic         issue_slot;
    logic         pc_ok;
    logic         issue;
    logic         fault_hit;

    assign out_fire   = out_valid_o & out_ready_i;
    assign issue_slot = (state_q == FETCH_RUN) & fetch_en_i & ~redirect_valid_i
                      & ((q_count != 2'd2) | out_fire);
    assign pc_ok      = pc_fetchable(pc_q, ADDR_WIDTH);
    assign issue      = issue_slot & pc_ok;
    assign fault_hit  = issue_slot & ~pc_ok;
    assign push_entry = '{pc: pc_q, inst: imem_data_i};

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i;
            fault_d = 1'b0;
        end else if (issue) begin
            pc_d = pc_q + PC_STEP;
        end else if (fault_hit) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
        end

        case (state_q)
            FETCH_IDLE:  if (fetch_en_i) state_d = FETCH_RUN;
            FETCH_RUN: begin
                if (!fetch_en_i)    state_d = FETCH_IDLE;
                else if (fault_hit) state_d = FETCH_FAULT;
            end
            FETCH_FAULT: if (redirect_valid_i) state_d = fetch_en_i ? FETCH_RUN : FETCH_IDLE;
            default:     state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // A redirect flushes the queue; a same-cycle pop of the old head is simply absorbed.
    imem_fetch_ctrl_skid_q u_skid_q (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (issue),
        .push_entry_i (push_entry),
        .pop_i        (out_fire),
        .flush_i      (redirect_valid_i),
        .count_o      (q_count),
        .head_o       (q_head)
    );

    assign imem_addr_o = {2'b00, pc_q[31:2]};
    assign out_valid_o = (q_count != 2'd0);
    assign out_inst_o  = q_head.inst;
    assign out_pc_o    = q_head.pc;
    assign fault_o     = fault_q;
    assign fault_pc_o  = fault_pc_q;

endmodule
